// File: rtl/array_output_serializer_if.sv
`default_nettype none
// ============================================================================
//  Module   : array_output_serializer_if
//  Purpose  : AXI4-Stream style bundle carrying serialized result elements.
//  Signals  : tdata  - one result element
//             tvalid - master has a beat available
//             tready - downstream can accept the beat
//             tlast  - final element of a matrix
//  Modports : master (drives tdata/tvalid/tlast), slave (drives tready)
//  Revision : 1.0 - initial release
// ============================================================================
interface array_output_serializer_if #(
  parameter int DATA_W = 32
) ();
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/array_output_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : array_output_serializer
//  Purpose  : Captures a complete N x N result matrix in one cycle and streams
//             it out element by element in row-major order on an AXI4-Stream
//             master port.
//  Ports    : i_clk        - clock, rising edge active
//             i_rst_n      - asynchronous active-low reset
//             i_c_valid    - flattened matrix on i_c_data is complete/stable
//             i_c_data     - N*N*DATA_W flattened matrix, (r,c) at (r*N+c)
//             o_c_ready    - block is idle and will capture on i_c_valid
//             m_axis       - stream master (tdata/tvalid/tready/tlast)
//             o_frame_done - one-cycle pulse after the last beat is accepted
//  Revision : 1.0 - initial release
// ============================================================================
module array_output_serializer #(
  parameter int N      = 4,
  parameter int DATA_W = 32
) (
  input  wire logic                    i_clk,
  input  wire logic                    i_rst_n,
  input  wire logic                    i_c_valid,
  input  wire logic [N*N*DATA_W-1:0]   i_c_data,
  output logic                         o_c_ready,
  array_output_serializer_if.master    m_axis,
  output logic                         o_frame_done
);

  localparam int                 c_NUM_ELEM = N * N;
  localparam int                 c_IDX_W    = (c_NUM_ELEM > 1) ? $clog2(c_NUM_ELEM) : 1;
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_NUM_ELEM - 1);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0]   r_bank [c_NUM_ELEM];
  logic                r_frame_done;
  logic                w_capture;
  logic                w_xfer;
  logic                w_last_xfer;

  // Next-state logic. Capture is only possible from IDLE, so a valid matrix
  // arriving on the edge that retires the last beat waits one more cycle;
  // that wait is the single tvalid=0 bubble between back-to-back frames.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_xfer      = 1'b0;
    w_last_xfer = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_c_valid) begin
          w_capture   = 1'b1;
          w_state_nxt = S_STREAM;
        end
      end
      S_STREAM: begin
        w_xfer = m_axis.tready;
        if (m_axis.tready && (r_idx == c_LAST_IDX)) begin
          w_last_xfer = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Bank, beat index and completion pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx        <= '0;
      r_frame_done <= 1'b0;
      for (int k = 0; k < c_NUM_ELEM; k++) begin
        r_bank[k] <= '0;
      end
    end else begin
      r_frame_done <= w_last_xfer;
      if (w_capture) begin
        r_idx <= '0;
        for (int k = 0; k < c_NUM_ELEM; k++) begin
          r_bank[k] <= i_c_data[k*DATA_W +: DATA_W];
        end
      end else if (w_xfer) begin
        r_idx <= w_last_xfer ? '0 : (r_idx + c_IDX_W'(1));
      end
    end
  end

  // All stream outputs are decoded from registers only, so they hold
  // naturally under backpressure and clear the instant reset asserts.
  assign o_c_ready     = (r_state == S_IDLE);
  assign m_axis.tvalid = (r_state == S_STREAM);
  assign m_axis.tlast  = (r_state == S_STREAM) && (r_idx == c_LAST_IDX);
  assign m_axis.tdata  = r_bank[r_idx];
  assign o_frame_done  = r_frame_done;

endmodule
`default_nettype wire
